// File: rtl/flash_dspi_responder_pkg.sv
// flash_dspi_responder_pkg: shared constants for the dual I/O fast-read protocol
package flash_dspi_responder_pkg;
   localparam logic [7:0] CMD_RD_DIO = 8'hBB;
   localparam logic [1:0] CONT_MATCH = 2'b10;
   localparam int CONT_HI = 5;
   localparam int CONT_LO = 4;
   localparam logic [5:0] CYC_ADDR = 6'd8;
   localparam logic [5:0] CYC_MODE = 6'd20;
   localparam logic [5:0] CYC_DATA = 6'd24;
   localparam logic [5:0] CYC_END = 6'd32;
   typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_MODE, ST_DATA, ST_IGNORE} state_t;
endpackage

// File: rtl/flash_dspi_responder_if.sv
// flash_dspi_responder_if: flash pins plus memory read port seen by the responder
interface flash_dspi_responder_if;
   logic spi_cs;
   logic [1:0] io_in;
   logic [1:0] io_out;
   logic [1:0] io_oe;
   logic mem_rd;
   logic [21:0] mem_addr;
   logic [15:0] mem_data;
   logic cont_mode;
   logic cmd_err;
   modport slave (
      input spi_cs, io_in, mem_data,
      output io_out, io_oe, mem_rd, mem_addr, cont_mode, cmd_err
   );
   modport master (
      output spi_cs, io_in, mem_data,
      input io_out, io_oe, mem_rd, mem_addr, cont_mode, cmd_err
   );
endinterface

// File: rtl/flash_dspi_responder.sv
// flash_dspi_responder: flash-side target for the dual I/O fast read (0xBB) with continuous mode
module flash_dspi_responder
   import flash_dspi_responder_pkg::*;
#(
   parameter logic [7:0] CMD = CMD_RD_DIO,
   parameter int READ_LAT = 2
) (
   input logic clk,
   input logic reset,
   flash_dspi_responder_if.slave bus
);
   state_t state, state_n, ph;
   logic [5:0] cyc, cyc_n;
   logic [20:0] sr, sr_n;
   logic [15:0] word, word_n, sh, sh_n, nw;
   logic [3:0] rd_pipe, rd_pipe_n;
   logic [1:0] io_out_n, io_oe_n;
   logic [21:0] mem_addr_n;
   logic [7:0] cmd_b;
   logic mem_rd_n, cont_n, cmd_err_n;
   logic act, cap, last_cmd, last_addr, last_mode, load, shifting;
   // decode the current phase and work out the next value of every register
   always_comb begin
      ph = (state == ST_IDLE) ? ((cyc == CYC_ADDR) ? ST_ADDR : ST_CMD) : state;
      act = !bus.spi_cs && ph != ST_IGNORE;
      cmd_b = {sr[6:0], bus.io_in[0]};
      cap = |(rd_pipe & (4'd1 << (READ_LAT - 1)));
      nw = cap ? bus.mem_data : word;
      last_cmd = act && ph == ST_CMD && cyc == CYC_ADDR - 6'd1;
      last_addr = act && ph == ST_ADDR && cyc == CYC_MODE - 6'd1;
      last_mode = act && ph == ST_MODE && cyc == CYC_DATA - 6'd1;
      load = last_mode || (act && ph == ST_DATA && cyc == CYC_END - 6'd1);
      shifting = act && ph == ST_DATA && !load;
      state_n = bus.spi_cs ? ST_IDLE :
                last_cmd ? ((cmd_b == CMD) ? ST_ADDR : ST_IGNORE) :
                last_addr ? ST_MODE :
                last_mode ? ST_DATA : ph;
      cont_n = last_mode ? (sr[CONT_HI-2:CONT_LO-2] == CONT_MATCH) :
               (bus.spi_cs && (state == ST_CMD || state == ST_ADDR || state == ST_MODE)) ? 1'b0 :
               bus.cont_mode;
      cyc_n = bus.spi_cs ? (cont_n ? CYC_ADDR : 6'd0) :
              (cyc == CYC_END - 6'd1) ? CYC_DATA : cyc + 6'd1;
      sr_n = !act ? sr : (ph == ST_CMD) ? {sr[19:0], bus.io_in[0]} : {sr[18:0], bus.io_in};
      word_n = nw;
      sh_n = load ? {nw[13:0], 2'b00} : {sh[13:0], 2'b00};
      rd_pipe_n = bus.spi_cs ? 4'd0 : {rd_pipe[2:0], bus.mem_rd};
      mem_rd_n = last_addr || load;
      mem_addr_n = last_addr ? {sr[20:0], bus.io_in[1]} : load ? bus.mem_addr + 22'd1 : bus.mem_addr;
      io_oe_n = (load || shifting) ? 2'b11 : 2'b00;
      io_out_n = load ? nw[15:14] : shifting ? sh[15:14] : 2'b00;
      cmd_err_n = last_cmd && cmd_b != CMD;
   end
   // register state and outputs; reset overrides any transfer in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cyc <= 6'd0;
         sr <= '0;
         word <= '0;
         sh <= '0;
         rd_pipe <= '0;
         bus.io_out <= 2'b00;
         bus.io_oe <= 2'b00;
         bus.mem_rd <= 1'b0;
         bus.mem_addr <= '0;
         bus.cont_mode <= 1'b0;
         bus.cmd_err <= 1'b0;
      end else begin
         state <= state_n;
         cyc <= cyc_n;
         sr <= sr_n;
         word <= word_n;
         sh <= sh_n;
         rd_pipe <= rd_pipe_n;
         bus.io_out <= io_out_n;
         bus.io_oe <= io_oe_n;
         bus.mem_rd <= mem_rd_n;
         bus.mem_addr <= mem_addr_n;
         bus.cont_mode <= cont_n;
         bus.cmd_err <= cmd_err_n;
      end
   end
endmodule

// File: tb/tb_flash_dspi_responder.sv
// tb_flash_dspi_responder: directed and randomized transfers checked against a transaction-level model
module tb_flash_dspi_responder;
   localparam int LAT = 2;
   localparam logic [7:0] RD = 8'hBB;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic spi_cs = 1'b1;
   logic [1:0] io_in = 2'b00;
   logic [15:0] pd [LAT];
   logic pv [LAT];
   logic [15:0] noise = 16'h0;
   logic exp_cont;
   int n_chk = 0;
   int n_err = 0;
   flash_dspi_responder_if bus();
   assign bus.spi_cs = spi_cs;
   assign bus.io_in = io_in;
   assign bus.mem_data = pv[LAT-1] ? pd[LAT-1] : noise;
   flash_dspi_responder #(.CMD(RD), .READ_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [15:0] rom(input logic [21:0] a);
      logic [31:0] h;
      h = {10'd0, a} * 32'h9E3779B1;
      return (a == 22'h123) ? 16'hA5C3 : h[31:16] ^ h[15:0];
   endfunction
   // behavioural ROM: data appears exactly LAT clocks after the strobe, noise otherwise
   always @(posedge clk) begin
      pd[0] <= rom(bus.mem_addr);
      pv[0] <= bus.mem_rd;
      for (int i = 1; i < LAT; i++) begin
         pd[i] <= pd[i-1];
         pv[i] <= pv[i-1];
      end
      noise <= 16'($urandom);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic xfer(input logic [7:0] cmd, input logic [23:0] ba, input logic [7:0] m,
                       input int nlow, input bit rst_end);
      int st, n, j, p;
      bit good, exp_rd;
      logic [21:0] wa, ea;
      logic [15:0] w;
      st = exp_cont ? 8 : 0;
      good = exp_cont || cmd == RD;
      wa = ba[22:1];
      for (int i = 0; i < nlow; i++) begin
         n = st + i;
         spi_cs = 1'b0;
         reset = rst_end && i == nlow - 1;
         io_in = (n < 8) ? {1'($urandom), cmd[7-n]} :
                 (n < 20) ? ba[23-2*(n-8) -: 2] :
                 (n < 24) ? m[7-2*(n-20) -: 2] : 2'($urandom);
         @(negedge clk);
         chk($sformatf("oe@%0d", n), 32'(bus.io_oe), (good && n >= 24) ? 32'd3 : 32'd0);
         exp_rd = good && (n == 20 || (n >= 24 && (n - 24) % 8 == 0));
         chk($sformatf("rd@%0d", n), 32'(bus.mem_rd), 32'(exp_rd));
         chk($sformatf("err@%0d", n), 32'(bus.cmd_err), 32'(!good && n == 8));
         if (exp_rd) begin
            ea = (n == 20) ? wa : 22'(wa + 22'(1 + (n - 24) / 8));
            chk($sformatf("addr@%0d", n), 32'(bus.mem_addr), 32'(ea));
         end
         if (good && n >= 24) begin
            j = (n - 24) / 8;
            p = (n - 24) % 8;
            w = rom(22'(wa + 22'(j)));
            chk($sformatf("dib@%0d", n), 32'(bus.io_out), 32'(w[15-2*p -: 2]));
         end
         if (good && n == 24)
            chk("cont@24", 32'(bus.cont_mode), 32'(m[5:4] == 2'b10));
         @(posedge clk);
         #1;
      end
      exp_cont = good && (st + nlow > 23) && m[5:4] == 2'b10;
      if (rst_end) begin
         reset = 1'b0;
         spi_cs = 1'b1;
         @(negedge clk);
         chk("rst_mid_oe", 32'(bus.io_oe), 32'd0);
         chk("rst_mid_cont", 32'(bus.cont_mode), 32'd0);
         chk("rst_mid_rd", 32'(bus.mem_rd), 32'd0);
         exp_cont = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         spi_cs = 1'b1;
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("end_oe", 32'(bus.io_oe), 32'd0);
         chk("end_rd", 32'(bus.mem_rd), 32'd0);
         chk("end_cont", 32'(bus.cont_mode), 32'(exp_cont));
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      exp_cont = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_io_out", 32'(bus.io_out), 32'd0);
      chk("rst_io_oe", 32'(bus.io_oe), 32'd0);
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_cont", 32'(bus.cont_mode), 32'd0);
      chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      xfer(RD, 24'h000246, 8'h20, 32, 1'b0);
      xfer(8'h00, 24'h7FFFFE, 8'h20, 40, 1'b0);
      xfer(8'h00, 24'hFFFFFF, 8'hFF, 16, 1'b0);
      xfer(RD, 24'h13579A, 8'hCF, 32, 1'b0);
      xfer(8'h03, 24'h000246, 8'h20, 30, 1'b0);
      xfer(RD, 24'h000246, 8'h20, 32, 1'b0);
      xfer(8'h00, 24'h2468AC, 8'h20, 20, 1'b1);
      for (int t = 0; t < 40; t++) begin
         int st, k, nl;
         logic [7:0] c, mm;
         logic [23:0] ba;
         st = exp_cont ? 8 : 0;
         k = $urandom_range(0, 9);
         c = (k < 2 && !exp_cont) ? 8'($urandom_range(0, 255)) : RD;
         if (k < 2 && !exp_cont && c == RD) c = 8'h03;
         mm = 8'($urandom);
         if (k % 2 == 1) mm[5:4] = 2'b10;
         ba = 24'($urandom);
         if (k == 9) ba[22:1] = 22'h3FFFFE + 22'($urandom_range(0, 1));
         nl = (k < 4) ? $urandom_range(1, 23 - st) : 24 - st + $urandom_range(8, 30);
         xfer(c, ba, mm, nl, 1'b0);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
